// File: rtl/wave_display_pkg.sv
// Shared constants and helpers for the waveform display pipeline.
package wave_display_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 9;
  localparam int PIPE_LAT = 2;

  localparam logic [10:0] X_WIN_LO = 11'd256;
  localparam logic [10:0] X_WIN_HI = 11'd767;
  localparam logic [9:0]  Y_WIN_HI = 10'd511;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  function automatic logic in_window(input logic v, input logic [10:0] px, input logic [9:0] py);
    return v && (px >= X_WIN_LO) && (px <= X_WIN_HI) && (py <= Y_WIN_HI);
  endfunction

  // Column is counted from the window's left edge, two pixels per sample.
  function automatic sample_t col_of(input logic [10:0] px);
    return sample_t'((px - X_WIN_LO) >> 1);
  endfunction

endpackage

// File: rtl/wave_seg_compare.sv
// Lights a pixel row when it lies between two consecutive samples (inclusive).
module wave_seg_compare
  import wave_display_pkg::*;
(
  input  logic [SAMPLE_W-1:0] i_prev,
  input  logic [SAMPLE_W-1:0] i_cur,
  input  logic [SAMPLE_W-1:0] i_ty,
  output logic                o_lit
);

  logic [SAMPLE_W-1:0] w_lo;
  logic [SAMPLE_W-1:0] w_hi;

  // Order the two samples, then range-check the row.
  always_comb begin
    w_lo  = (i_prev <= i_cur) ? i_prev : i_cur;
    w_hi  = (i_prev <= i_cur) ? i_cur  : i_prev;
    o_lit = (i_ty >= w_lo) && (i_ty <= w_hi);
  end

endmodule

// File: rtl/wave_display.sv
// Draws a continuous waveform trace from the sample RAM into the VGA pixel stream.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [23:0] TRACE_RGB = 24'h00FF00,
  parameter logic [23:0] BG_RGB    = 24'h000000
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              read_index,
  input  logic [7:0]        read_value,
  output logic [8:0]        read_address,
  output logic              valid_pixel,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              wave_display_idle
);

  addr_t   r_read_address;
  logic    r_in_win_s1;
  sample_t r_ty_s1;
  logic    r_first_s1;
  logic    r_hist_ok;
  addr_t   r_last_addr;
  sample_t r_prev;
  sample_t r_cur;
  logic    r_valid_pixel;
  logic [23:0] r_rgb;
  logic    r_idle;

  logic    w_first;
  logic    w_load;
  sample_t w_prev_nxt;
  sample_t w_cur_nxt;
  logic    w_seg_lit;
  logic    w_lit;

  // Until the first window column after reset, every load behaves like a first column.
  always_comb begin
    w_first    = r_first_s1 | ~r_hist_ok;
    w_load     = (r_read_address != r_last_addr) | w_first;
    w_cur_nxt  = w_load  ? read_value : r_cur;
    w_prev_nxt = w_first ? read_value : (w_load ? r_cur : r_prev);
    w_lit      = r_in_win_s1 & w_seg_lit;
  end

  wave_seg_compare u_seg (
    .i_prev (w_prev_nxt),
    .i_cur  (w_cur_nxt),
    .i_ty   (r_ty_s1),
    .o_lit  (w_seg_lit)
  );

  // Stage 1: address the RAM and carry the pixel context alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_address <= 9'd0;
      r_in_win_s1    <= 1'b0;
      r_ty_s1        <= 8'd0;
      r_first_s1     <= 1'b0;
      r_idle         <= 1'b1;
    end else begin
      r_read_address <= {read_index, col_of(x)};
      r_in_win_s1    <= in_window(valid, x, y);
      r_ty_s1        <= y[8:1];
      r_first_s1     <= (col_of(x) == 8'd0);
      r_idle         <= !(valid && (y <= Y_WIN_HI));
    end
  end

  // Stage 2: sample history plus the registered pixel colour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist_ok     <= 1'b0;
      r_last_addr   <= 9'd0;
      r_prev        <= 8'd0;
      r_cur         <= 8'd0;
      r_valid_pixel <= 1'b0;
      r_rgb         <= 24'h000000;
    end else begin
      r_hist_ok     <= r_hist_ok | r_in_win_s1;
      r_last_addr   <= r_read_address;
      r_prev        <= w_prev_nxt;
      r_cur         <= w_cur_nxt;
      r_valid_pixel <= r_in_win_s1;
      r_rgb         <= w_lit ? TRACE_RGB : (r_in_win_s1 ? BG_RGB : 24'h000000);
    end
  end

  assign read_address      = r_read_address;
  assign valid_pixel       = r_valid_pixel;
  assign r                 = r_rgb[23:16];
  assign g                 = r_rgb[15:8];
  assign b                 = r_rgb[7:0];
  assign wave_display_idle = r_idle;

endmodule

// File: tb/tb_wave_display.sv
// Directed, table-driven checks for wave_display against a behavioural sample RAM.
module tb_wave_display;

  logic        clk;
  logic        rst_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  logic [7:0] ram [512];
  int n_pass;
  int n_total;

  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLK = 24'h000000;

  typedef struct {
    logic        idx;
    logic [10:0] px;
    logic [9:0]  py;
    logic        v;
    logic        evp;
    logic [23:0] ergb;
    logic        eidle;
  } vec_t;

  vec_t tbl [19];

  wave_display dut (
    .clk               (clk),
    .reset             (rst_n),
    .x                 (x),
    .y                 (y),
    .valid             (valid),
    .read_index        (read_index),
    .read_value        (read_value),
    .read_address      (read_address),
    .valid_pixel       (valid_pixel),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .wave_display_idle (wave_display_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM data register lives in the DUT's address register.
  assign read_value = ram[read_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic idx, input logic [10:0] px, input logic [9:0] py, input logic v);
    read_index = idx;
    x          = px;
    y          = py;
    valid      = v;
  endtask

  task automatic pix(input string name, input logic evp, input logic [23:0] ergb);
    check({name, "_vp"},  {31'd0, valid_pixel}, {31'd0, evp});
    check({name, "_rgb"}, {8'd0, r, g, b},      {8'd0, ergb});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 512; i++) ram[i] = 8'd100;
    ram[0]       = 8'd10;
    ram[21]      = 8'd40;
    ram[22]      = 8'd60;
    ram[255]     = 8'd255;
    ram[256+21]  = 8'd60;
    ram[256+22]  = 8'd40;

    tbl[0]  = '{1'b0, 11'd354, 10'd200, 1'b1, 1'b1, GRN, 1'b0};
    tbl[1]  = '{1'b0, 11'd356, 10'd200, 1'b1, 1'b1, GRN, 1'b0};
    tbl[2]  = '{1'b0, 11'd356, 10'd202, 1'b1, 1'b1, BLK, 1'b0};
    tbl[3]  = '{1'b0, 11'd298, 10'd80,  1'b1, 1'b1, GRN, 1'b0};
    tbl[4]  = '{1'b0, 11'd300, 10'd80,  1'b1, 1'b1, GRN, 1'b0};
    tbl[5]  = '{1'b0, 11'd300, 10'd100, 1'b1, 1'b1, GRN, 1'b0};
    tbl[6]  = '{1'b0, 11'd300, 10'd120, 1'b1, 1'b1, GRN, 1'b0};
    tbl[7]  = '{1'b0, 11'd300, 10'd78,  1'b1, 1'b1, BLK, 1'b0};
    tbl[8]  = '{1'b0, 11'd300, 10'd122, 1'b1, 1'b1, BLK, 1'b0};
    tbl[9]  = '{1'b1, 11'd0,   10'd0,   1'b0, 1'b0, BLK, 1'b1};
    tbl[10] = '{1'b1, 11'd298, 10'd80,  1'b1, 1'b1, BLK, 1'b0};
    tbl[11] = '{1'b1, 11'd300, 10'd80,  1'b1, 1'b1, GRN, 1'b0};
    tbl[12] = '{1'b1, 11'd300, 10'd100, 1'b1, 1'b1, GRN, 1'b0};
    tbl[13] = '{1'b1, 11'd300, 10'd120, 1'b1, 1'b1, GRN, 1'b0};
    tbl[14] = '{1'b1, 11'd300, 10'd78,  1'b1, 1'b1, BLK, 1'b0};
    tbl[15] = '{1'b1, 11'd300, 10'd122, 1'b1, 1'b1, BLK, 1'b0};
    tbl[16] = '{1'b0, 11'd300, 10'd600, 1'b1, 1'b0, BLK, 1'b1};
    tbl[17] = '{1'b0, 11'd100, 10'd10,  1'b1, 1'b0, BLK, 1'b0};
    tbl[18] = '{1'b0, 11'd300, 10'd10,  1'b0, 1'b0, BLK, 1'b1};

    // Power-on reset.
    rst_n = 1'b0;
    drive(1'b0, 11'd0, 10'd0, 1'b0);
    tick(); tick();
    pix("por", 1'b0, BLK);
    check("por_addr", {23'd0, read_address}, 32'd0);
    check("por_idle", {31'd0, wave_display_idle}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Table: each pixel is held for the full pipeline latency.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].idx, tbl[i].px, tbl[i].py, tbl[i].v);
      tick(); tick();
      pix($sformatf("vec%0d", i), tbl[i].evp, tbl[i].ergb);
      check($sformatf("vec%0d_idle", i), {31'd0, wave_display_idle}, {31'd0, tbl[i].eidle});
    end

    // Addressing, one cycle per pixel.
    drive(1'b1, 11'd300, 10'd10, 1'b1); tick();
    check("addr_300", {23'd0, read_address}, 32'h116);
    drive(1'b1, 11'd301, 10'd10, 1'b1); tick();
    check("addr_301", {23'd0, read_address}, 32'h116);
    drive(1'b1, 11'd302, 10'd10, 1'b1); tick();
    check("addr_302", {23'd0, read_address}, 32'h117);

    // First column must not fill from the previous row's last sample.
    drive(1'b0, 11'd766, 10'd20, 1'b1); tick(); tick();
    pix("col255_ty10", 1'b1, BLK);
    drive(1'b0, 11'd256, 10'd20, 1'b1); tick(); tick();
    pix("col0_ty10", 1'b1, GRN);
    drive(1'b0, 11'd256, 10'd22, 1'b1); tick(); tick();
    pix("col0_ty11", 1'b1, BLK);
    drive(1'b0, 11'd256, 10'd400, 1'b1); tick(); tick();
    pix("col0_ty200", 1'b1, BLK);
    drive(1'b0, 11'd256, 10'd18, 1'b1); tick(); tick();
    pix("col0_ty9", 1'b1, BLK);

    // Reset mid-stream, then check the 2-cycle latency on release.
    drive(1'b0, 11'd356, 10'd200, 1'b1); tick(); tick();
    pix("pre_rst", 1'b1, GRN);
    #2 rst_n = 1'b0;
    #1;
    pix("rst_async", 1'b0, BLK);
    check("rst_async_addr", {23'd0, read_address}, 32'd0);
    check("rst_async_idle", {31'd0, wave_display_idle}, 32'd1);
    tick(); tick(); tick();
    pix("rst_hold", 1'b0, BLK);
    check("rst_hold_addr", {23'd0, read_address}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_lat1_vp", {31'd0, valid_pixel}, 32'd0);
    check("rel_lat1_addr", {23'd0, read_address}, 32'h032);
    check("rel_lat1_idle", {31'd0, wave_display_idle}, 32'd0);
    tick();
    pix("rel_lat2", 1'b1, GRN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
